instr_decode: RTL and testbench

//  MIPS-32 control decoder for the P6 five-stage pipeline; one instance per stage needing control.

---
 rtl/instr_decode.sv | 146 ++++++++++++++
 tb/tb_instr_decode.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//   MIPS-32 control decoder for the P6 five-stage pipeline. Maps a 32-bit
//   instruction word to data-memory controls (MemWrite, DMLOp, DMSOp) and the
//   general controls RegWrite, IsLoad and Illegal. Decode is combinational.
//   IllSeen is a sticky flag that records any illegal instruction seen at a
//   clock edge since the last reset.
//
//   Optional feature macro: DECODE_REG_OUT_EN
//     undefined (default) : controls follow instr combinationally (latency 0)
//     defined             : controls are registered on posedge clk (latency 1),
//                           cleared by reset, and IllSeen is set from the
//                           registered Illegal.
//
//   Reset is synchronous and active-low (reset = 0 clears at posedge clk).
// -----------------------------------------------------------------------------
module instr_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        MemWrite,
  output logic [3:0]  DMLOp,
  output logic [3:0]  DMSOp,
  output logic        RegWrite,
  output logic        IsLoad,
  output logic        Illegal,
  output logic        IllSeen
);

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Load / store type encodings carried on DMLOp / DMSOp
  typedef enum logic [3:0] {
    DML_NONE = 4'd0, DML_LW = 4'd1, DML_LB = 4'd2,
    DML_LBU  = 4'd3, DML_LH = 4'd4, DML_LHU = 4'd5
  } dml_e;

  typedef enum logic [3:0] {
    DMS_NONE = 4'd0, DMS_SW = 4'd1, DMS_SB = 4'd2, DMS_SH = 4'd3
  } dms_e;

  typedef struct packed {
    logic       mem_write;
    dml_e       dml_op;
    dms_e       dms_op;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  ctrl_t      w_ctrl;   // combinational decode
  ctrl_t      w_out;    // decode as presented on the outputs
  logic       r_ill_seen;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];

  // Decode opcode/funct into controls; anything unlisted is illegal. The case
  // items match exactly, so X/Z on opcode or funct falls to the illegal default.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // control unassigned, which would otherwise infer a latch.
    w_ctrl = '{mem_write: 1'b0, dml_op: DML_NONE, dms_op: DMS_NONE,
               reg_write: 1'b0, illegal: 1'b0};
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR,
          FN_SLT, FN_SLTU, FN_SLL:         w_ctrl.reg_write = 1'b1;
          FN_JR:                           w_ctrl.reg_write = 1'b0;
          default:                         w_ctrl.illegal   = 1'b1;
        endcase
      end
      OP_LW:  begin w_ctrl.dml_op = DML_LW;  w_ctrl.reg_write = 1'b1; end
      OP_LB:  begin w_ctrl.dml_op = DML_LB;  w_ctrl.reg_write = 1'b1; end
      OP_LBU: begin w_ctrl.dml_op = DML_LBU; w_ctrl.reg_write = 1'b1; end
      OP_LH:  begin w_ctrl.dml_op = DML_LH;  w_ctrl.reg_write = 1'b1; end
      OP_LHU: begin w_ctrl.dml_op = DML_LHU; w_ctrl.reg_write = 1'b1; end
      OP_SW:  begin w_ctrl.dms_op = DMS_SW;  w_ctrl.mem_write = 1'b1; end
      OP_SB:  begin w_ctrl.dms_op = DMS_SB;  w_ctrl.mem_write = 1'b1; end
      OP_SH:  begin w_ctrl.dms_op = DMS_SH;  w_ctrl.mem_write = 1'b1; end
      OP_ORI, OP_ADDIU, OP_LUI, OP_JAL:      w_ctrl.reg_write = 1'b1;
      OP_BEQ, OP_BNE, OP_J:                  w_ctrl.reg_write = 1'b0;
      default:                               w_ctrl.illegal   = 1'b1;
    endcase
  end

`ifdef DECODE_REG_OUT_EN
  ctrl_t r_ctrl;

  // Register the decoded controls for one cycle of latency; reset clears them.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) r_ctrl <= '{mem_write: 1'b0, dml_op: DML_NONE, dms_op: DMS_NONE,
                            reg_write: 1'b0, illegal: 1'b0};
    else        r_ctrl <= w_ctrl;
  end

  assign w_out = r_ctrl;
`else
  assign w_out = w_ctrl;
`endif

  // Sticky illegal flag: reset wins over a simultaneous illegal instruction.
  always_ff @(posedge clk) begin
    if (!reset)             r_ill_seen <= 1'b0;
    else if (w_out.illegal) r_ill_seen <= 1'b1;
  end

  assign MemWrite = w_out.mem_write;
  assign DMLOp    = w_out.dml_op;
  assign DMSOp    = w_out.dms_op;
  assign RegWrite = w_out.reg_write;
  assign IsLoad   = (w_out.dml_op != DML_NONE);
  assign Illegal  = w_out.illegal;
  assign IllSeen  = r_ill_seen;

endmodule

// File: tb/tb_instr_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_decode
//   Scoreboard bench for instr_decode (default build, combinational decode).
//   Stimulus drives one instruction per cycle just after posedge and pushes the
//   hand-computed expected controls; a monitor pops and compares on negedge.
// -----------------------------------------------------------------------------
module tb_instr_decode;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        MemWrite;
  logic [3:0]  DMLOp;
  logic [3:0]  DMSOp;
  logic        RegWrite;
  logic        IsLoad;
  logic        Illegal;
  logic        IllSeen;

  typedef struct packed {
    logic [31:0] ins;
    logic        mw;
    logic [3:0]  ml;
    logic [3:0]  ms;
    logic        rw;
    logic        ld;
    logic        il;
    logic        seen;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic seen_model = 1'b0;   // expected IllSeen as of the current cycle

  instr_decode dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .MemWrite (MemWrite),
    .DMLOp    (DMLOp),
    .DMSOp    (DMSOp),
    .RegWrite (RegWrite),
    .IsLoad   (IsLoad),
    .Illegal  (Illegal),
    .IllSeen  (IllSeen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] ins,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s instr=%08h got=%0h expected=%0h", name, ins, act, exp);
    end
  endtask

  // Expected-value builders: mw, DMLOp, DMSOp, RegWrite, IsLoad, Illegal
  function automatic exp_t mk(input logic mw, input logic [3:0] ml,
                              input logic [3:0] ms, input logic rw,
                              input logic ld, input logic il);
    exp_t e;
    e      = '0;
    e.mw   = mw;
    e.ml   = ml;
    e.ms   = ms;
    e.rw   = rw;
    e.ld   = ld;
    e.il   = il;
    return e;
  endfunction

  // Present one instruction for a cycle; rst_low drives reset=0 for that edge.
  task automatic apply(input logic [31:0] ins, input exp_t e, input bit rst_low);
    @(posedge clk);
    #1;
    reset = rst_low ? 1'b0 : 1'b1;
    instr = ins;
    e.ins  = ins;
    e.seen = seen_model;
    q.push_back(e);
    seen_model = rst_low ? 1'b0 : (seen_model | e.il);
  endtask

  // Monitor: compare the DUT against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("MemWrite", e.ins, {31'd0, MemWrite}, {31'd0, e.mw});
      check("DMLOp",    e.ins, {28'd0, DMLOp},    {28'd0, e.ml});
      check("DMSOp",    e.ins, {28'd0, DMSOp},    {28'd0, e.ms});
      check("RegWrite", e.ins, {31'd0, RegWrite}, {31'd0, e.rw});
      check("IsLoad",   e.ins, {31'd0, IsLoad},   {31'd0, e.ld});
      check("Illegal",  e.ins, {31'd0, Illegal},  {31'd0, e.il});
      check("IllSeen",  e.ins, {31'd0, IllSeen},  {31'd0, e.seen});
    end
  end

  initial begin
    exp_t LW, LB, LBU, LH, LHU, SW, SB, SH, RW1, RW0, ILL;
    LW  = mk(1'b0, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0);
    LB  = mk(1'b0, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    LBU = mk(1'b0, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0);
    LH  = mk(1'b0, 4'd4, 4'd0, 1'b1, 1'b1, 1'b0);
    LHU = mk(1'b0, 4'd5, 4'd0, 1'b1, 1'b1, 1'b0);
    SW  = mk(1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    SB  = mk(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    SH  = mk(1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    RW1 = mk(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    RW0 = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    ILL = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    reset = 1'b0;
    instr = 32'hFC00_0000;   // illegal during reset must not set IllSeen
    repeat (2) @(posedge clk);

    // Loads (including one with all non-opcode bits set)
    apply(32'h8C02_0004, LW,  1'b0);
    apply(32'h8002_0004, LB,  1'b0);
    apply(32'h9002_0004, LBU, 1'b0);
    apply(32'h8402_0004, LH,  1'b0);
    apply(32'h9402_0004, LHU, 1'b0);
    apply(32'h8FFF_FFFF, LW,  1'b0);
    // Stores
    apply(32'hAC03_0000, SW,  1'b0);
    apply(32'hA003_0001, SB,  1'b0);
    apply(32'hA403_0002, SH,  1'b0);
    // R-type
    apply(32'h0085_1021, RW1, 1'b0);   // addu
    apply(32'h03FF_F821, RW1, 1'b0);   // addu, rs/rt/rd all ones
    apply(32'h0085_1023, RW1, 1'b0);   // subu
    apply(32'h0085_1024, RW1, 1'b0);   // and
    apply(32'h0085_1025, RW1, 1'b0);   // or
    apply(32'h0085_102A, RW1, 1'b0);   // slt
    apply(32'h0085_102B, RW1, 1'b0);   // sltu
    apply(32'h0000_0000, RW1, 1'b0);   // nop (sll $0)
    apply(32'h0000_07C0, RW1, 1'b0);   // sll with shamt
    apply(32'h03E0_0008, RW0, 1'b0);   // jr $ra
    // I/J-type
    apply(32'h34A5_FFFF, RW1, 1'b0);   // ori
    apply(32'h24A5_0001, RW1, 1'b0);   // addiu
    apply(32'h3C01_ABCD, RW1, 1'b0);   // lui
    apply(32'h0C10_0000, RW1, 1'b0);   // jal
    apply(32'h10A0_0003, RW0, 1'b0);   // beq
    apply(32'h14A0_0003, RW0, 1'b0);   // bne
    apply(32'h0800_0010, RW0, 1'b0);   // j
    // Illegal encodings and sticky flag
    apply(32'hFC00_0000, ILL, 1'b0);   // IllSeen still 0 here, 1 after edge
    apply(32'h8C02_0004, LW,  1'b0);   // IllSeen now 1
    apply(32'h0000_0001, ILL, 1'b0);   // R-type unlisted funct
    apply(32'h0000_003F, ILL, 1'b0);
    apply(32'h8800_0000, ILL, 1'b0);   // lwl not supported
    apply(32'h2000_0000, ILL, 1'b0);   // addi not supported
    apply(32'hA403_0002, SH,  1'b0);
    // Reset edge with a simultaneous illegal instruction: reset wins
    apply(32'hFC00_0000, ILL, 1'b1);
    apply(32'h0000_0000, RW1, 1'b0);   // IllSeen cleared
    apply(32'hAC03_0000, SW,  1'b0);

    // Drain: the monitor must have consumed every expected entry
    repeat (3) @(posedge clk);
    check("drain", 32'h0, q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
